// File: rtl/cpu_pkg.sv
// Shared CPU types: widths, opcodes, IF/ID register layout.
// No logic; types and constants only.
// No backpressure; not applicable.
package cpu_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 20;
    localparam int OPC_W   = 5;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [OPC_W-1:0]   opcode_t;

    localparam opcode_t OPC_ADD   = 5'b00000;
    localparam opcode_t OPC_SUB   = 5'b00001;
    localparam opcode_t OPC_AND   = 5'b00010;
    localparam opcode_t OPC_OR    = 5'b00011;
    localparam opcode_t OPC_XOR   = 5'b00100;
    localparam opcode_t OPC_SLT   = 5'b00101;
    localparam opcode_t OPC_ADDI  = 5'b00110;
    localparam opcode_t OPC_LOAD  = 5'b00111;
    localparam opcode_t OPC_STORE = 5'b01000;
    localparam opcode_t OPC_JUMP  = 5'b01001;
    localparam opcode_t OPC_BEQZ  = 5'b01010;
    localparam opcode_t OPC_BEQ   = 5'b01011;

    typedef struct packed {
        logic   valid;
        instr_t instr;
        pc_t    pc;
        pc_t    pc_plus1;
    } ifid_t;

    function automatic pc_t pc_inc(input pc_t p);
        return p + pc_t'(1);
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; kill wins over hold, hold wins over load. Optional FETCH_JUMP_PREDECODE_EN adds the predecoded flag.
// Latency: 1 cycle from fetch inputs to registered outputs.
// Backpressure: hold freezes every field; kill inserts a bubble (valid=0, instr=0).
module ifid_reg #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               kill,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [PC_W-1:0]    fetch_pc,
    input  logic [PC_W-1:0]    fetch_pc_plus1,
`ifdef FETCH_JUMP_PREDECODE_EN
    input  logic               fetch_predec,
    output logic               ifid_predecoded,
`endif
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_plus1
);

    typedef struct packed {
        logic               valid;
`ifdef FETCH_JUMP_PREDECODE_EN
        logic               predec;
`endif
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus1;
    } slot_t;

    slot_t slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (kill) begin
            // Bubble still records the address; only valid/instr are defined for decode.
            slot_d.valid    = 1'b0;
            slot_d.instr    = '0;
            slot_d.pc       = fetch_pc;
            slot_d.pc_plus1 = fetch_pc_plus1;
`ifdef FETCH_JUMP_PREDECODE_EN
            slot_d.predec   = 1'b0;
`endif
        end else if (!hold) begin
            slot_d.valid    = 1'b1;
            slot_d.instr    = fetch_instr;
            slot_d.pc       = fetch_pc;
            slot_d.pc_plus1 = fetch_pc_plus1;
`ifdef FETCH_JUMP_PREDECODE_EN
            slot_d.predec   = fetch_predec;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign ifid_valid    = slot_q.valid;
    assign ifid_instr    = slot_q.instr;
    assign ifid_pc       = slot_q.pc;
    assign ifid_pc_plus1 = slot_q.pc_plus1;
`ifdef FETCH_JUMP_PREDECODE_EN
    assign ifid_predecoded = slot_q.predec;
`endif

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux, IF/ID capture. FETCH_JUMP_PREDECODE_EN enables in-stage jump following.
// Latency: memory word at pc reaches IF/ID one cycle later.
// Backpressure: stall holds pc and IF/ID; redirect overrides stall and inserts a bubble.
module fetch_stage #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
`ifdef FETCH_JUMP_PREDECODE_EN
    parameter logic [4:0] OPC_JUMP = cpu_pkg::OPC_JUMP,
`endif
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
`ifdef FETCH_JUMP_PREDECODE_EN
    output logic               ifid_predecoded,
`endif
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_plus1
);

    import cpu_pkg::*;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus1;
    logic            ifid_kill;

    assign pc       = pc_q;
    assign pc_plus1 = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef FETCH_JUMP_PREDECODE_EN
    opcode_t fetch_opc;
    logic    jump_hit;
    assign fetch_opc = instruction[INSTR_W-1 -: OPC_W];
    assign jump_hit  = (fetch_opc == OPC_JUMP);
`endif

    always_comb begin
        pc_d = pc_plus1;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
`ifdef FETCH_JUMP_PREDECODE_EN
        end else if (jump_hit) begin
            pc_d = instruction[PC_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A plain flush yields to stall; a redirect kills regardless.
    assign ifid_kill = redirect_valid | (flush & ~stall);

    ifid_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_ifid_reg (
        .clk            (clk),
        .reset          (reset),
        .hold           (stall),
        .kill           (ifid_kill),
        .fetch_instr    (instruction),
        .fetch_pc       (pc_q),
        .fetch_pc_plus1 (pc_plus1),
`ifdef FETCH_JUMP_PREDECODE_EN
        .fetch_predec   (jump_hit),
        .ifid_predecoded(ifid_predecoded),
`endif
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1)
    );

endmodule
